// File: rtl/vram_scan_arbiter.sv
// Shares one single-port frame-buffer BRAM between up-scaled scan-out reads and draw-engine writes.
// Pixel data is 2 cycles behind hen/ven; a write waits at most 1 cycle (read slots only), never stalls in blanking.
module vram_scan_arbiter #(
   parameter int H_ACT       = 800,
   parameter int V_ACT       = 600,
   parameter int SCALE_SHIFT = 2,
   parameter int DW          = 12,
   parameter int AW          = 15
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          hen,
   input  logic          ven,
   input  logic          hs,
   input  logic          vs,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] rgb,
   output logic          hs_o,
   output logic          vs_o,
   output logic          den_o,
   output logic          frame_done
);
   localparam int                     FB_W     = H_ACT >> SCALE_SHIFT;
   localparam int                     FB_H     = V_ACT >> SCALE_SHIFT;
   localparam logic [AW:0]            FB_SIZE  = (AW+1)'(FB_W * FB_H);
   localparam logic [AW-1:0]          ROW_STEP = AW'(FB_W);
   localparam logic [SCALE_SHIFT-1:0] SUB_LAST = '1;
   localparam logic [SCALE_SHIFT-1:0] SUB_ONE  = SCALE_SHIFT'(1);

   logic [10:0]            x;
   logic                   hen_d;
   logic                   ven_d;
   logic [SCALE_SHIFT-1:0] sub_y;
   logic [AW-1:0]          row_base;
   logic                   slot_d;
   logic [DW-1:0]          pix;
   logic [1:0]             hs_pipe;
   logic [1:0]             vs_pipe;
   logic [1:0]             den_pipe;

   logic                   active;
   logic                   slot;
   logic                   line_end;
   logic                   in_range;
   logic [AW-1:0]          rd_addr;

   always_comb begin
      active   = hen & ven;
      slot     = active & (x[SCALE_SHIFT-1:0] == '0);
      line_end = hen_d & ~hen & ven;
      rd_addr  = row_base + AW'(x >> SCALE_SHIFT);
      in_range = {1'b0, wr_addr} < FB_SIZE;
   end

   // Out-of-range writes still handshake; only the BRAM strobe is suppressed.
   assign wr_ready   = ~slot;
   assign mem_addr   = (slot & rstn) ? rd_addr : wr_addr;
   assign mem_we     = rstn & ~slot & wr_valid & in_range;
   assign mem_wdata  = wr_data;

   assign rgb        = den_o ? pix : '0;
   assign hs_o       = hs_pipe[1];
   assign vs_o       = vs_pipe[1];
   assign den_o      = den_pipe[1];
   assign frame_done = rstn & ven_d & ~ven;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         x        <= '0;
         hen_d    <= 1'b0;
         ven_d    <= 1'b0;
         sub_y    <= '0;
         row_base <= '0;
         slot_d   <= 1'b0;
         pix      <= '0;
         hs_pipe  <= '0;
         vs_pipe  <= '0;
         den_pipe <= '0;
      end else begin
         hen_d <= hen;
         ven_d <= ven;
         x     <= active ? x + 11'd1 : 11'd0;

         // Vertical blanking overrides a coincident line end so each frame restarts at row 0.
         if (!ven) begin
            sub_y    <= '0;
            row_base <= '0;
         end else if (line_end) begin
            sub_y <= sub_y + SUB_ONE;
            if (sub_y == SUB_LAST) begin
               row_base <= row_base + ROW_STEP;
            end
         end

         slot_d <= slot;
         if (slot_d) begin
            pix <= mem_rdata;
         end

         hs_pipe  <= {hs_pipe[0], hs};
         vs_pipe  <= {vs_pipe[0], vs};
         den_pipe <= {den_pipe[0], active};
      end
   end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Self-checking bench for vram_scan_arbiter: table vectors, reset and frame sequences, random write traffic.
module tb_vram_scan_arbiter;
   localparam int AW  = 15;
   localparam int DW  = 12;
   localparam int FBW = 200;
   localparam int FBN = 30000;

   logic          clk = 1'b0;
   logic          rstn, hen, ven, hs, vs, wr_valid;
   logic          wr_ready, mem_we, hs_o, vs_o, den_o, frame_done;
   logic [AW-1:0] wr_addr, mem_addr;
   logic [DW-1:0] wr_data, mem_wdata, mem_rdata, rgb;

   int checks = 0;
   int errors = 0;

   vram_scan_arbiter dut (
      .clk(clk), .rstn(rstn), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rgb(rgb), .hs_o(hs_o), .vs_o(vs_o), .den_o(den_o), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'(a * 37 + 5);
   endfunction

   // Synchronous single-port BRAM, read-first, 1-cycle read latency.
   logic [DW-1:0] bram [0:(1<<AW)-1];
   initial for (int i = 0; i < (1<<AW); i++) bram[i] = init_val(i);
   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   // Reference model: expected frame-buffer contents plus a 2-deep history of expected outputs.
   typedef struct packed {
      logic          den;
      logic          hs;
      logic          vs;
      logic [DW-1:0] rgb;
      logic          ok;
      logic          rgb_ok;
   } hist_t;

   logic [DW-1:0] mdl [0:(1<<AW)-1];
   hist_t         hq0 = '0;
   hist_t         hq1 = '0;
   logic          prev_ven = 1'b0;
   logic          synced = 1'b0;
   logic [DW-1:0] cur_pix = '0;
   int            fd_cnt = 0;
   int            acc_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Drive one cycle's inputs and check every output against the model at the falling edge.
   task automatic cyc_a(input logic r, input logic h, input logic v, input logic hsi, input logic vsi,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input int px, input int line);
      logic act, slot, rdy, we, fd_exp;
      int   ra;
      rstn = r; hen = h; ven = v; hs = hsi; vs = vsi;
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      @(negedge clk);
      act    = h & v;
      slot   = act && (px % 4 == 0);
      rdy    = !slot;
      we     = r && wv && rdy && (int'(wa) < FBN);
      ra     = (line / 4) * FBW + px / 4;
      fd_exp = r && prev_ven && !v;
      if (!r) synced = 1'b0;
      else if (!v) synced = 1'b1;

      if (!r) begin
         chk("mem_we_in_reset", mem_we, 0);
      end else if (synced) begin
         chk("wr_ready", wr_ready, rdy);
         chk("mem_we", mem_we, we);
         if (slot) begin
            chk("rd_addr", mem_addr, ra);
         end else begin
            chk("wr_addr_pass", mem_addr, wa);
            chk("wr_data_pass", mem_wdata, wd);
         end
      end
      chk("frame_done", frame_done, fd_exp);
      if (hq1.ok) begin
         chk("den_o", den_o, hq1.den);
         chk("hs_o", hs_o, hq1.hs);
         chk("vs_o", vs_o, hq1.vs);
         if (hq1.rgb_ok || !hq1.den) chk("rgb", rgb, hq1.rgb);
      end

      if (frame_done) fd_cnt++;
      if (r && wv && wr_ready) acc_cnt++;
      if (we) mdl[wa] = wd;
      if (slot && r) cur_pix = mdl[ra];

      if (!r) begin
         hq0 = '0;
         hq0.ok = 1'b1;
         hq0.rgb_ok = 1'b1;
         hq1 = hq0;
      end else begin
         hq1 = hq0;
         hq0.den = act;
         hq0.hs = hsi;
         hq0.vs = vsi;
         hq0.rgb = act ? cur_pix : '0;
         hq0.ok = 1'b1;
         hq0.rgb_ok = synced;
      end
      prev_ven = r & v;
   endtask

   task automatic cyc_b();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic r, input logic h, input logic v, input logic hsi, input logic vsi,
                      input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input int px, input int line);
      cyc_a(r, h, v, hsi, vsi, wv, wa, wd, px, line);
      cyc_b();
   endtask

   // One frame: 4 vertical-blank lines, then nlines active lines (first nlong are 800 pixels, rest 8).
   task automatic frame(input int nlines, input int nlong);
      fd_cnt = 0;
      for (int l = 0; l < 4; l++) begin
         for (int c = 0; c < 16; c++) begin
            cyc(1'b1, c < 8, 1'b0, c == 10 || c == 11, l == 1 || l == 2,
                1'($urandom), AW'($urandom_range(0, 32767)), DW'($urandom), 0, 0);
         end
      end
      for (int l = 0; l < nlines; l++) begin
         int alen;
         alen = (l < nlong) ? 800 : 8;
         for (int p = 0; p < alen + 8; p++) begin
            logic a, v, wv;
            logic [AW-1:0] wa;
            a  = p < alen;
            v  = a || (l != nlines - 1);
            wv = (l == 0) ? 1'b0 : (l == 1) ? 1'b1 : 1'($urandom);
            wa = (l == 1) ? AW'($urandom_range(0, FBN - 1)) : AW'($urandom_range(0, 32767));
            if (l == 1 && p == 0) acc_cnt = 0;
            cyc(1'b1, a, v, !a && (p - alen == 2 || p - alen == 3), 1'b0,
                wv, wa, DW'($urandom), a ? p : 0, l);
            if (l == 1 && p == alen - 1) chk("writes_per_active_line", acc_cnt, alen - alen / 4);
            if (l == 1 && p == alen + 7) chk("writes_incl_hblank", acc_cnt, alen - alen / 4 + 8);
         end
      end
      for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0);
      chk("frame_done_pulses", fd_cnt, 1);
   endtask

   typedef struct {
      logic          wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          rdy;
      logic          we;
   } vec_t;

   initial begin
      vec_t tbl [6];
      tbl[0] = '{1'b1, 15'd0,     12'h123, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 15'd29999, 12'hABC, 1'b1, 1'b1};
      tbl[2] = '{1'b1, 15'd30000, 12'h555, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 15'd32767, 12'hFFF, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 15'd100,   12'h0F0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 15'd199,   12'h00F, 1'b1, 1'b1};

      for (int i = 0; i < (1<<AW); i++) mdl[i] = init_val(i);
      rstn = 1'b0; hen = 1'b0; ven = 1'b0; hs = 1'b0; vs = 1'b0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      @(posedge clk);
      #1;

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0);

      // Handshake and range vectors applied during blanking.
      for (int i = 0; i < 6; i++) begin
         cyc_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tbl[i].wv, tbl[i].wa, tbl[i].wd, 0, 0);
         chk("tbl_wr_ready", wr_ready, tbl[i].rdy);
         chk("tbl_mem_we", mem_we, tbl[i].we);
         cyc_b();
      end

      // Partial active line, then reset mid-line with syncs and a write request held high.
      for (int p = 0; p < 10; p++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, p, 0);
      repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 15'd5, 12'h7, 0, 0);
      cyc_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0);
      chk("post_reset_rgb", rgb, 0);
      chk("post_reset_den_o", den_o, 0);
      chk("post_reset_hs_o", hs_o, 0);
      chk("post_reset_vs_o", vs_o, 0);
      chk("post_reset_mem_we", mem_we, 0);
      cyc_b();
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0);

      frame(600, 5);
      frame(600, 0);
      frame(8, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
